// File: rtl/vball_oki_pkg.sv
// Shared tables and types for the 4-voice OKI ADPCM player.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents: STEP quantiser table, ADJ step-index deltas, VOL attenuation
// multipliers, FSM state enum and two small helper functions.
package vball_oki_pkg;

    localparam logic [10:0] STEP [0:48] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    localparam logic signed [4:0] ADJ [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    localparam logic [5:0] VOL [0:8] = '{
        6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd5, 6'd4, 6'd3, 6'd2
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TBL_RD,
        ST_V_FETCH,
        ST_V_DECODE,
        ST_MIX
    } state_t;

    // Lowest set bit of a voice mask; callers guarantee the mask is non-zero.
    function automatic logic [1:0] lowest_voice(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else if (m[3]) return 2'd3;
        else           return 2'd0;
    endfunction

    // (signal * mult) >>> 5 with mult from VOL; attenuation codes above 8 mute.
    function automatic logic signed [12:0] vol_scale(input logic signed [11:0] sig,
                                                     input logic [3:0]         att);
        logic [5:0]         mult;
        logic signed [18:0] prod;
        mult = (att <= 4'd8) ? VOL[att] : 6'd0;
        prod = sig * $signed({1'b0, mult});
        return 13'(prod >>> 5);
    endfunction

endpackage

// File: rtl/vball_adpcm_decode.sv
// One OKI ADPCM nibble step: (nibble, signal, step index) -> (signal', index').
// Latency: purely combinational.
// Backpressure: none; shared by all voices, the caller selects the operands.
//
// Ports: nibble[3:0], sig_in[11:0] signed, idx_in[5:0] -> sig_out[11:0], idx_out[5:0].
module vball_adpcm_decode
    import vball_oki_pkg::*;
(
    input  logic        [3:0]  nibble,
    input  logic signed [11:0] sig_in,
    input  logic        [5:0]  idx_in,
    output logic signed [11:0] sig_out,
    output logic        [5:0]  idx_out
);

    logic        [10:0] step;
    logic        [12:0] diff;
    logic signed [13:0] sig_ext;
    logic signed [13:0] diff_ext;
    logic signed [13:0] sum;
    logic signed [4:0]  adj;
    logic signed [6:0]  idx_sum;

    always_comb begin
        step = STEP[idx_in];
        diff = {5'd0, step[10:3]};
        if (nibble[0]) diff = diff + {4'd0, step[10:2]};
        if (nibble[1]) diff = diff + {3'd0, step[10:1]};
        if (nibble[2]) diff = diff + {2'd0, step};

        sig_ext  = {{2{sig_in[11]}}, sig_in};
        diff_ext = {1'b0, diff};
        sum      = nibble[3] ? (sig_ext - diff_ext) : (sig_ext + diff_ext);

        if (sum > 14'sd2047)
            sig_out = 12'sd2047;
        else if (sum < -14'sd2048)
            sig_out = -12'sd2048;
        else
            sig_out = sum[11:0];

        adj     = ADJ[nibble[2:0]];
        idx_sum = $signed({1'b0, idx_in}) + $signed({{2{adj[4]}}, adj});
        if (idx_sum < 7'sd0)
            idx_out = 6'd0;
        else if (idx_sum > 7'sd48)
            idx_out = 6'd48;
        else
            idx_out = idx_sum[5:0];
    end

endmodule

// File: rtl/vball_oki_adpcm.sv
// 4-voice OKI ADPCM phrase player on the sound-CPU bus; one mixed sample per sample_ce.
// Latency: sample updated within 4*(ROM_LAT+3)+8 clk_sys cycles of sample_ce.
// Backpressure: none; CPU writes are edge-detected, one start is queued, frames are latched.
//
// Ports: clk_sys/reset_n; sample_ce strobe; cs/wr/din/dout CPU bus (dout is 0 unless cs&~wr);
// rom_addr/rom_rd/rom_data fixed-latency sample ROM; sample (signed 16-bit mix); busy[3:0].
module vball_oki_adpcm
    import vball_oki_pkg::*;
#(
    parameter int ROM_AW  = 18,
    parameter int ROM_LAT = 1
)(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              sample_ce,
    input  logic              cs,
    input  logic              wr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_data,
    output logic [15:0]       sample,
    output logic [3:0]        busy
);

    localparam int WW = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

    state_t state, state_nxt;

    // CPU command state
    logic        wr_prev, awaiting;
    logic [6:0]  phrase;
    logic        pend_vld;
    logic [6:0]  pend_phrase;
    logic [1:0]  pend_voice;
    logic [3:0]  pend_att;
    logic        ce_pend;

    // Sequencer state
    logic [6:0]  cur_phrase;
    logic [1:0]  cur_voice;
    logic [3:0]  cur_att;
    logic [WW-1:0] wcnt;
    logic [2:0]  tcnt;
    logic [1:0]  vsel;
    logic [3:0]  active;     // voices that were playing when the current frame began
    logic [7:0]  rom_byte;
    logic [17:0] tbl_start;
    logic [9:0]  tbl_end_hi;

    // Per-voice state
    logic [ROM_AW-1:0]  v_addr [4];
    logic [ROM_AW-1:0]  v_end  [4];
    logic signed [11:0] v_sig  [4];
    logic [5:0]         v_idx  [4];
    logic [3:0]         v_nib;   // 1: next nibble is the high one
    logic [3:0]         v_att  [4];

    logic wr_acc, ce_take, start_go, start_drop, lat_done, tbl_last;
    logic [17:0] end_full;
    logic [3:0]  nibble;
    logic signed [11:0] dec_sig;
    logic [5:0]  dec_idx;
    logic signed [12:0] vol [4];
    logic signed [13:0] mix_sum;

    assign wr_acc     = cs & wr & ~wr_prev;
    assign ce_take    = (state == ST_IDLE) && (sample_ce || ce_pend);
    assign start_go   = (state == ST_IDLE) && !ce_take && pend_vld && !busy[pend_voice];
    assign start_drop = (state == ST_IDLE) && !ce_take && pend_vld &&  busy[pend_voice];
    assign lat_done   = (wcnt == WW'(ROM_LAT));
    assign tbl_last   = lat_done && (tcnt == 3'd5);
    assign end_full   = {tbl_end_hi, rom_data};
    assign nibble     = v_nib[vsel] ? rom_byte[7:4] : rom_byte[3:0];
    assign dout       = (cs & ~wr) ? {4'h0, busy} : 8'h00;

    vball_adpcm_decode u_dec (
        .nibble  (nibble),
        .sig_in  (v_sig[vsel]),
        .idx_in  (v_idx[vsel]),
        .sig_out (dec_sig),
        .idx_out (dec_idx)
    );

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < 4; i++) begin
            vol[i]  = active[i] ? vol_scale(v_sig[i], v_att[i]) : 13'sd0;
            mix_sum = mix_sum + {vol[i][12], vol[i]};
        end
    end

    // FSM: state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ce_take)       state_nxt = ST_V_FETCH;
                else if (start_go) state_nxt = ST_TBL_RD;
            end
            ST_TBL_RD:   if (tbl_last) state_nxt = ST_IDLE;
            ST_V_FETCH: begin
                // Idle voices are skipped in a single cycle without a ROM read.
                if (!active[vsel])  state_nxt = (vsel == 2'd3) ? ST_MIX : ST_V_FETCH;
                else if (lat_done)  state_nxt = ST_V_DECODE;
            end
            ST_V_DECODE: state_nxt = (vsel == 2'd3) ? ST_MIX : ST_V_FETCH;
            ST_MIX:      state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs (one read per table byte / voice, issued when the wait counter is 0)
    always_comb begin
        rom_rd   = 1'b0;
        rom_addr = '0;
        case (state)
            ST_TBL_RD: begin
                rom_rd   = (wcnt == '0);
                rom_addr = ROM_AW'({cur_phrase, tcnt});
            end
            ST_V_FETCH: begin
                rom_rd   = active[vsel] && (wcnt == '0);
                rom_addr = v_addr[vsel];
            end
            default: ;
        endcase
    end

    // Datapath. Later assignments in this block take priority: CPU commands
    // override the sequencer (newest start wins, stop beats a same-cycle start).
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_prev     <= 1'b0;
            awaiting    <= 1'b0;
            phrase      <= '0;
            pend_vld    <= 1'b0;
            pend_phrase <= '0;
            pend_voice  <= '0;
            pend_att    <= '0;
            ce_pend     <= 1'b0;
            cur_phrase  <= '0;
            cur_voice   <= '0;
            cur_att     <= '0;
            wcnt        <= '0;
            tcnt        <= '0;
            vsel        <= '0;
            active      <= '0;
            rom_byte    <= '0;
            tbl_start   <= '0;
            tbl_end_hi  <= '0;
            v_nib       <= '0;
            busy        <= '0;
            sample      <= '0;
            for (int i = 0; i < 4; i++) begin
                v_addr[i] <= '0;
                v_end[i]  <= '0;
                v_sig[i]  <= '0;
                v_idx[i]  <= '0;
                v_att[i]  <= '0;
            end
        end else begin
            wr_prev <= cs & wr;
            ce_pend <= (ce_pend | sample_ce) & ~ce_take;

            case (state)
                ST_IDLE: begin
                    wcnt <= '0;
                    tcnt <= '0;
                    vsel <= '0;
                    if (ce_take) begin
                        active <= busy;
                    end else if (start_go) begin
                        cur_phrase <= pend_phrase;
                        cur_voice  <= pend_voice;
                        cur_att    <= pend_att;
                        pend_vld   <= 1'b0;
                    end else if (start_drop) begin
                        pend_vld   <= 1'b0;
                    end
                end
                ST_TBL_RD: begin
                    if (lat_done) begin
                        wcnt <= '0;
                        tcnt <= tcnt + 3'd1;
                        case (tcnt)
                            3'd0: tbl_start[17:16] <= rom_data[1:0];
                            3'd1: tbl_start[15:8]  <= rom_data;
                            3'd2: tbl_start[7:0]   <= rom_data;
                            3'd3: tbl_end_hi[9:8]  <= rom_data[1:0];
                            3'd4: tbl_end_hi[7:0]  <= rom_data;
                            default: ;
                        endcase
                        if (tbl_last && (end_full >= tbl_start)) begin
                            v_addr[cur_voice] <= ROM_AW'(tbl_start);
                            v_end[cur_voice]  <= ROM_AW'(end_full);
                            v_sig[cur_voice]  <= '0;
                            v_idx[cur_voice]  <= '0;
                            v_nib[cur_voice]  <= 1'b1;
                            v_att[cur_voice]  <= cur_att;
                            busy[cur_voice]   <= 1'b1;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_V_FETCH: begin
                    if (!active[vsel]) begin
                        wcnt <= '0;
                        vsel <= vsel + 2'd1;
                    end else if (lat_done) begin
                        wcnt     <= '0;
                        rom_byte <= rom_data;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_V_DECODE: begin
                    v_sig[vsel] <= dec_sig;
                    v_idx[vsel] <= dec_idx;
                    v_nib[vsel] <= ~v_nib[vsel];
                    if (!v_nib[vsel]) begin
                        v_addr[vsel] <= v_addr[vsel] + 1'b1;
                        if (v_addr[vsel] == v_end[vsel]) busy[vsel] <= 1'b0;
                    end
                    vsel <= vsel + 2'd1;
                end
                ST_MIX: sample <= {mix_sum, 2'b00};
                default: ;
            endcase

            if (wr_acc) begin
                if (awaiting) begin
                    awaiting <= 1'b0;
                    if ((din[7:4] != 4'd0) && (phrase != 7'd0)) begin
                        pend_vld    <= 1'b1;
                        pend_phrase <= phrase;
                        pend_voice  <= lowest_voice(din[7:4]);
                        pend_att    <= din[3:0];
                    end
                end else if (din[7]) begin
                    phrase   <= din[6:0];
                    awaiting <= 1'b1;
                end else begin
                    // Clearing active as well mutes the voice in a frame already under way.
                    for (int i = 0; i < 4; i++) begin
                        if (din[3+i]) begin
                            busy[i]   <= 1'b0;
                            active[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vball_oki_adpcm.sv
// Self-checking bench for vball_oki_adpcm with a 1-cycle-latency ROM model.
// Expected frame results are queued when a playback scenario is set up and
// popped/compared after each sample_ce frame completes.
module tb_vball_oki_adpcm;

    localparam int ROM_AW       = 18;
    localparam int FRAME_BUDGET = 4 * (1 + 3) + 8;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              sample_ce = 1'b0;
    logic              cs = 1'b0;
    logic              wr = 1'b0;
    logic [7:0]        din = 8'h00;
    logic [7:0]        dout;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_rd;
    logic [7:0]        rom_data = 8'h00;
    logic [15:0]       sample;
    logic [3:0]        busy;

    logic [7:0] mem [0:(1<<ROM_AW)-1];

    typedef struct {
        logic [15:0] smp;
        logic [3:0]  bsy;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int frame_no = 0;

    vball_oki_adpcm #(.ROM_AW(ROM_AW), .ROM_LAT(1)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .sample_ce (sample_ce),
        .cs        (cs),
        .wr        (wr),
        .din       (din),
        .dout      (dout),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
        .rom_data  (rom_data),
        .sample    (sample),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (rom_rd) rom_data <= mem[rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    task automatic cpu_write(input logic [7:0] b);
        @(posedge clk_sys); #1;
        cs = 1'b1; wr = 1'b1; din = b;
        repeat (3) @(posedge clk_sys);
        #1;
        cs = 1'b0; wr = 1'b0;
        repeat (2) @(posedge clk_sys);
    endtask

    task automatic wait_busy(input logic [3:0] want, input string tag);
        int n;
        n = 0;
        @(negedge clk_sys);
        while (busy !== want && n < 60) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, busy, want);
    endtask

    task automatic push_frame(input logic [15:0] s, input logic [3:0] b);
        exp_t e;
        e.smp = s;
        e.bsy = b;
        exp_q.push_back(e);
    endtask

    task automatic run_frames();
        exp_t e;
        while (exp_q.size() > 0) begin
            @(posedge clk_sys); #1 sample_ce = 1'b1;
            @(posedge clk_sys); #1 sample_ce = 1'b0;
            repeat (FRAME_BUDGET) @(posedge clk_sys);
            @(negedge clk_sys);
            e = exp_q.pop_front();
            check($sformatf("frame%0d_sample", frame_no), sample, e.smp);
            check($sformatf("frame%0d_busy", frame_no), busy, e.bsy);
            frame_no++;
        end
    endtask

    task automatic settle();
        repeat (40) @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << ROM_AW); i++) mem[i] = 8'h00;
        // phrase 1: start 0x100, end 0x100
        mem[8]  = 8'h00; mem[9]  = 8'h01; mem[10] = 8'h00;
        mem[11] = 8'h00; mem[12] = 8'h01; mem[13] = 8'h00;
        // phrase 2: start 0x200, end 0x20F
        mem[16] = 8'h00; mem[17] = 8'h02; mem[18] = 8'h00;
        mem[19] = 8'h00; mem[20] = 8'h02; mem[21] = 8'h0F;
        // phrase 3: end before start, must not play
        mem[24] = 8'h00; mem[25] = 8'h03; mem[26] = 8'h00;
        mem[27] = 8'h00; mem[28] = 8'h02; mem[29] = 8'hFF;
        mem[18'h100] = 8'h78;
        for (int a = 18'h200; a <= 18'h20F; a++) mem[a] = 8'h77;

        // Reset state
        cs = 1'b1; wr = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_sample", sample, 16'd0);
        check("rst_busy", busy, 4'd0);
        check("rst_dout", dout, 8'd0);
        check("rst_rom_rd", rom_rd, 1'b0);
        @(posedge clk_sys); #1 reset_n = 1'b1; cs = 1'b0;
        repeat (2) @(posedge clk_sys);

        // Phrase 1 on voice 0, att 0: two frames then idle
        cpu_write(8'h81);
        cpu_write(8'h10);
        wait_busy(4'b0001, "p1_busy_after_table");
        cs = 1'b1; wr = 1'b0;
        @(negedge clk_sys);
        check("dout_readback", dout, 8'h01);
        cs = 1'b0;
        @(negedge clk_sys);
        check("dout_deselected", dout, 8'h00);
        push_frame(16'd120, 4'b0001);
        push_frame(16'd104, 4'b0000);
        push_frame(16'd0,   4'b0000);
        run_frames();

        // Same phrase with att 2
        cpu_write(8'h81);
        cpu_write(8'h12);
        wait_busy(4'b0001, "p1_att2_busy");
        push_frame(16'd60, 4'b0001);
        push_frame(16'd52, 4'b0000);
        run_frames();

        // Phrase 2 (0x77 stream); a start aimed at the busy voice is ignored; saturation
        cpu_write(8'h82);
        cpu_write(8'h10);
        wait_busy(4'b0001, "p2_busy");
        push_frame(16'd120, 4'b0001);
        run_frames();
        cpu_write(8'h81);
        cpu_write(8'h10);
        settle();
        push_frame(16'd372,  4'b0001);
        push_frame(16'd916,  4'b0001);
        push_frame(16'd2088, 4'b0001);
        push_frame(16'd4612, 4'b0001);
        push_frame(16'd8188, 4'b0001);
        push_frame(16'd8188, 4'b0001);
        push_frame(16'd8188, 4'b0001);
        run_frames();

        // Stop voice 0: busy clears the cycle after the write is accepted
        @(posedge clk_sys); #1;
        cs = 1'b1; wr = 1'b1; din = 8'h08;
        @(posedge clk_sys); #1;
        check("stop_busy_next_cycle", busy, 4'b0000);
        repeat (2) @(posedge clk_sys);
        #1 cs = 1'b0; wr = 1'b0;
        repeat (2) @(posedge clk_sys);
        push_frame(16'd0, 4'b0000);
        run_frames();

        // Discarded starts: phrase 0, empty mask, end < start
        cpu_write(8'h80);
        cpu_write(8'h10);
        settle();
        check("phrase0_ignored", busy, 4'b0000);
        cpu_write(8'h81);
        cpu_write(8'h00);
        settle();
        check("mask0_ignored", busy, 4'b0000);
        cpu_write(8'h83);
        cpu_write(8'h20);
        settle();
        check("end_lt_start_ignored", busy, 4'b0000);

        // Multiple mask bits: lowest voice (1) is used
        cpu_write(8'h82);
        cpu_write(8'h60);
        wait_busy(4'b0010, "mask_lowest_voice");
        push_frame(16'd120, 4'b0010);
        run_frames();

        // Reset in the middle of a frame
        @(posedge clk_sys); #1 sample_ce = 1'b1;
        @(posedge clk_sys); #1 sample_ce = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b0; cs = 1'b1; wr = 1'b0;
        #1;
        check("midrst_sample", sample, 16'd0);
        check("midrst_busy", busy, 4'd0);
        check("midrst_dout", dout, 8'd0);
        check("midrst_rom_rd", rom_rd, 1'b0);
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1; cs = 1'b0;
        push_frame(16'd0, 4'b0000);
        run_frames();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
